// File: rtl/complex_addsub_pipe_pkg.sv
// Shared definitions for the complex add/sub pipeline: mode encoding,
// re/im slice positions within a packed {re, im} word, and per-lane op decode.
package cplx_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ADDC = 2'b10,
    MODE_SUBC = 2'b11
  } cplx_mode_e;

  localparam int unsigned CPLX_IM_LSB = 0;

  function automatic int unsigned re_lsb(input int unsigned w);
    return w;
  endfunction

  function automatic int unsigned re_msb(input int unsigned w);
    return 2 * w - 1;
  endfunction

  function automatic int unsigned im_msb(input int unsigned w);
    return w - 1;
  endfunction

  function automatic logic re_is_sub(input cplx_mode_e m);
    return (m == MODE_SUB) || (m == MODE_SUBC);
  endfunction

  // Conjugating B flips the sign applied to b.im relative to the re lane.
  function automatic logic im_is_sub(input cplx_mode_e m);
    return (m == MODE_SUB) || (m == MODE_ADDC);
  endfunction

endpackage

// File: rtl/complex_addsub_pipe_if.sv
// Stream interface for complex_addsub_pipe: input sample handshake plus
// result handshake; master drives samples and out_ready, slave is the pipe.
interface complex_addsub_pipe_if #(
  parameter int unsigned W = 32
);

  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] a;
  logic [2*W-1:0] b;
  logic [1:0]     mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic [1:0]     ovf;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result, ovf
  );

endinterface

// File: rtl/complex_addsub_pipe_lane.sv
// cplx_lane: combinational W-bit signed add/sub with overflow detect.
// Build option CPLX_ADDSUB_SAT_EN saturates overflowing results instead of wrapping.
module cplx_lane #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] z,
  output logic         ovf
);

  logic [W:0] xe;
  logic [W:0] ye;
  logic [W:0] sum;

  always_comb begin
    xe  = {x[W-1], x};
    ye  = {y[W-1], y};
    // The W+1-bit result is exact, so the top two bits disagree only on overflow.
    sum = sub ? (xe - ye) : (xe + ye);
    ovf = sum[W] ^ sum[W-1];
`ifdef CPLX_ADDSUB_SAT_EN
    if (ovf) begin
      z = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      z = sum[W-1:0];
    end
`else
    z = sum[W-1:0];
`endif
  end

endmodule

// File: rtl/complex_addsub_pipe.sv
// complex_addsub_pipe: LAT-stage complex add/sub/conjugate pipeline with
// valid/ready flow control and ce. Build option: CPLX_ADDSUB_SAT_EN (saturate).
module complex_addsub_pipe #(
  parameter int unsigned W   = 32,
  parameter int unsigned LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  complex_addsub_pipe_if.slave  bus
);

  import cplx_pkg::*;

  localparam int unsigned RE_HI = re_msb(W);
  localparam int unsigned RE_LO = re_lsb(W);
  localparam int unsigned IM_HI = im_msb(W);
  localparam int unsigned SW    = 2 * W + 2;

  logic [LAT-1:0]         valid_q;
  logic [LAT-1:0]         valid_d;
  logic [LAT-1:0][SW-1:0] stage_q;
  logic [LAT-1:0][SW-1:0] stage_d;

  cplx_mode_e mode_e;
  logic       re_sub;
  logic       im_sub;
  logic [W-1:0] re_z;
  logic [W-1:0] im_z;
  logic         re_ovf;
  logic         im_ovf;
  logic         advance;

  always_comb begin
    mode_e = cplx_mode_e'(bus.mode);
    re_sub = re_is_sub(mode_e);
    im_sub = im_is_sub(mode_e);
  end

  cplx_lane #(.W(W)) u_lane_re (
    .x   (bus.a[RE_HI:RE_LO]),
    .y   (bus.b[RE_HI:RE_LO]),
    .sub (re_sub),
    .z   (re_z),
    .ovf (re_ovf)
  );

  cplx_lane #(.W(W)) u_lane_im (
    .x   (bus.a[IM_HI:CPLX_IM_LSB]),
    .y   (bus.b[IM_HI:CPLX_IM_LSB]),
    .sub (im_sub),
    .z   (im_z),
    .ovf (im_ovf)
  );

  // Stage 0 captures the finished arithmetic; later stages only delay it.
  always_comb begin
    advance = ce && !(valid_q[LAT-1] && !bus.out_ready);
    valid_d = valid_q;
    stage_d = stage_q;
    if (advance) begin
      valid_d[0] = bus.in_valid;
      stage_d[0] = {re_z, im_z, re_ovf, im_ovf};
      for (int unsigned i = 1; i < LAT; i++) begin
        valid_d[i] = valid_q[i-1];
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      stage_q <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    bus.in_ready  = advance;
    bus.out_valid = valid_q[LAT-1];
    bus.result    = stage_q[LAT-1][SW-1:2];
    bus.ovf       = stage_q[LAT-1][1:0];
  end

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Self-checking bench for complex_addsub_pipe (W=16, LAT=2): directed vectors
// with literal expectations plus a queue-based reference model checked every cycle.
module tb_complex_addsub_pipe;

  localparam int unsigned W   = 16;
  localparam int unsigned LAT = 2;
  localparam int          MAXV = 2 ** (W - 1) - 1;
  localparam int          MINV = -(2 ** (W - 1));
`ifdef CPLX_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic ce;

  complex_addsub_pipe_if #(.W(W)) bus ();

  complex_addsub_pipe #(.W(W), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;
  int unsigned n_popped = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else n_passed++;
  endtask

  // One component: exact integer result, then overflow and wrap/saturate.
  function automatic logic [W:0] lane(input logic [W-1:0] x, input logic [W-1:0] y, input bit sub);
    int r;
    logic [W-1:0] z;
    bit o;
    r = sub ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
    o = (r > MAXV) || (r < MINV);
    if (o && SAT) z = (r > 0) ? 16'h7FFF : 16'h8000;
    else          z = r[W-1:0];
    return {o, z};
  endfunction

  function automatic logic [2*W+1:0] model(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                           input logic [1:0] m);
    logic [W:0] re;
    logic [W:0] im;
    bit im_sub;
    im_sub = m[1] ? ~m[0] : m[0];
    re = lane(a[2*W-1:W], b[2*W-1:W], m[0]);
    im = lane(a[W-1:0], b[W-1:0], im_sub);
    return {re[W-1:0], im[W-1:0], re[W], im[W]};
  endfunction

  typedef struct {
    logic [2*W-1:0] res;
    logic [1:0]     ovf;
    int unsigned    age;
  } exp_t;
  exp_t q[$];

  // Each queued sample ages by one per accepted advance; it is visible at age LAT.
  always @(negedge clk) begin
    bit vis;
    bit adv;
    exp_t e;
    logic [2*W+1:0] mv;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_ovf", bus.ovf, 0);
    end else begin
      vis = (q.size() > 0) && (q[0].age >= LAT);
      chk("out_valid", bus.out_valid, vis);
      if (vis) begin
        chk("result", bus.result, q[0].res);
        chk("ovf", bus.ovf, q[0].ovf);
      end
      adv = ce && !(vis && !bus.out_ready);
      chk("in_ready", bus.in_ready, adv);
      if (adv) begin
        if (vis) begin
          void'(q.pop_front());
          n_popped++;
        end
        foreach (q[i]) q[i].age++;
        if (bus.in_valid) begin
          mv    = model(bus.a, bus.b, bus.mode);
          e.res = mv[2*W+1:2];
          e.ovf = mv[1:0];
          e.age = 1;
          q.push_back(e);
        end
      end
    end
  end

  // Called just after a rising edge with an idle pipeline.
  task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] m, input logic [31:0] er, input logic [1:0] eo);
    logic [33:0] mv;
    mv = model(a, b, m);
    chk({nm, "_model"}, mv, {er, eo});
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.mode = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, "_early"}, bus.out_valid, 0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk({nm, "_result"}, bus.result, er);
    chk({nm, "_ovf"}, bus.ovf, eo);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    int unsigned n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.mode = m;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    clk = 1'b0;
    rst_n = 1'b0;
    ce = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.mode = 2'b00;
    #2;
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_result", bus.result, 0);
    chk("init_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    pin("add",   32'h0003_0004, 32'h0001_FFFE, 2'b00, 32'h0004_0002, 2'b00);
    pin("subc",  32'h0005_0005, 32'h0002_0003, 2'b11, 32'h0003_0008, 2'b00);
    pin("addc",  32'h0005_0005, 32'h0002_0003, 2'b10, 32'h0007_0002, 2'b00);
    pin("ovf_pos", 32'h7FFF_0000, 32'h0001_0000, 2'b00,
        SAT ? 32'h7FFF_0000 : 32'h8000_0000, 2'b10);
    pin("ovf_neg", 32'h8000_0001, 32'h0001_0001, 2'b01,
        SAT ? 32'h8000_0000 : 32'h7FFF_0000, 2'b10);
    pin("conj_min", 32'h0000_0000, 32'h0000_8000, 2'b10,
        SAT ? 32'h0000_7FFF : 32'h0000_8000, 2'b01);

    // Eight back-to-back samples with a three-cycle downstream stall.
    base = n_popped;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send({16'(k * 4660), 16'(16'h7FF0 + k * 3)},
               {16'(16'h7000 - k * 257), 16'(k * 9 - 20)}, 2'(k));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("stream_count", n_popped - base, 8);
    chk("stream_drained", q.size(), 0);

    // Clock enable low for two cycles adds exactly two cycles of latency.
    bus.in_valid = 1'b1;
    bus.a = 32'h0010_0020;
    bus.b = 32'h0001_0002;
    bus.mode = 2'b01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ce_frozen", bus.out_valid, 0);
    ce = 1'b1;
    @(posedge clk); #1;
    chk("ce_valid", bus.out_valid, 1);
    chk("ce_result", bus.result, 32'h000F_001E);
    repeat (2) @(posedge clk);
    #1;

    // Reset with two samples in flight.
    bus.in_valid = 1'b1;
    bus.a = 32'h0100_0200;
    bus.b = 32'h0001_0001;
    bus.mode = 2'b00;
    @(posedge clk); #1;
    bus.a = 32'h0300_0400;
    @(posedge clk); #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_result", bus.result, 0);
    chk("async_rst_ovf", bus.ovf, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_no_stale", bus.out_valid, 0);
    pin("post_rst", 32'h0002_FFFF, 32'h0003_0001, 2'b01, 32'hFFFF_FFFE, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
